// File: rtl/uart_rx_wrapper.sv
// Multi-byte UART receiver: oversampled 8N1 byte receiver plus MSB-byte-first frame assembly.
// Optional 8E1 line format is enabled with `define UART_RX_PARITY_EN.
module uart_rx_wrapper #(
  parameter int unsigned SYS_CLK_PERIOD   = 50,
  parameter int unsigned BAUD_RATE        = 115200,
  parameter int unsigned BYTE_NUM         = 9,
  parameter int unsigned TIMEOUT_BIT_NUM  = 20,
  parameter int unsigned VALID_PERIOD_NUM = 1
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  input  logic                    SDATA_I,
  output logic [BYTE_NUM*8-1:0]   DATA_O,
  output logic                    VALID_O,
  output logic                    BUSY_O,
  output logic                    ERR_O
);

  localparam int unsigned BAUD_DIV = 1000000000 / (SYS_CLK_PERIOD * BAUD_RATE);
  localparam int unsigned HALF_DIV = BAUD_DIV / 2;
  localparam int unsigned DW       = BYTE_NUM * 8;
  localparam int unsigned BCW      = $clog2(BAUD_DIV + 1);
  localparam int unsigned CW       = $clog2(BYTE_NUM + 1);
  localparam int unsigned TO_CYC   = TIMEOUT_BIT_NUM * BAUD_DIV;
  localparam int unsigned TW       = $clog2(TO_CYC + 1);
  localparam int unsigned VW       = $clog2(VALID_PERIOD_NUM + 1);

  localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);
  localparam logic [BCW-1:0] HALF_LAST = BCW'(HALF_DIV - 1);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(BYTE_NUM - 1);
  localparam logic [TW-1:0]  TO_LAST   = TW'(TO_CYC - 1);
  localparam logic [VW-1:0]  VLD_LAST  = VW'(VALID_PERIOD_NUM - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY    = 3'd5;
`endif

  logic           r_rx_s1, r_rx_s2, r_rx_d;
  logic [2:0]     r_state;
  logic [BCW-1:0] r_baud;
  logic [2:0]     r_bit;
  logic [7:0]     r_byte;
  logic [CW-1:0]  r_cnt;
  logic [DW-1:0]  r_asm, r_data;
  logic [TW-1:0]  r_idle;
  logic [VW-1:0]  r_vcnt;
  logic           r_valid, r_busy, r_err;

  logic w_rx_s, w_fall, w_baud_hit, w_half_hit;
  logic w_start_ok, w_byte_ok, w_frm_err, w_par_err, w_byte_err, w_timeout, w_frame_done;
  logic [DW-1:0] w_asm_next;

  assign w_rx_s       = r_rx_s2;
  assign w_fall       = r_rx_d & ~w_rx_s;
  assign w_baud_hit   = (r_baud == BAUD_LAST);
  assign w_half_hit   = (r_baud == HALF_LAST);
  assign w_start_ok   = (r_state == S_START) && w_half_hit && !w_rx_s;
  assign w_byte_ok    = (r_state == S_STOP) && w_baud_hit && w_rx_s;
  assign w_frm_err    = (r_state == S_STOP) && w_baud_hit && !w_rx_s;
`ifdef UART_RX_PARITY_EN
  assign w_par_err    = (r_state == S_PARITY) && w_baud_hit && (^{r_byte, w_rx_s});
`else
  assign w_par_err    = 1'b0;
`endif
  assign w_byte_err   = w_frm_err | w_par_err;
  assign w_timeout    = (r_state == S_IDLE) && (r_cnt != '0) && (r_idle == TO_LAST);
  assign w_frame_done = w_byte_ok && (r_cnt == CNT_LAST);
  assign w_asm_next   = (r_asm << 8) | DW'(r_byte);

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_rx_s1 <= SDATA_I;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          if (w_fall) r_state <= S_START;
        end
        S_START: begin
          if (w_half_hit) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= w_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_baud <= r_baud + BCW'(1);
          end
        end
        S_DATA: begin
          if (w_baud_hit) begin
            r_baud <= '0;
            r_byte <= {w_rx_s, r_byte[7:1]};
            r_bit  <= r_bit + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (r_bit == 3'd7) r_state <= S_PARITY;
`else
            if (r_bit == 3'd7) r_state <= S_STOP;
`endif
          end else begin
            r_baud <= r_baud + BCW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_baud_hit) begin
            r_baud  <= '0;
            r_state <= w_par_err ? S_WAIT_HIGH : S_STOP;
          end else begin
            r_baud <= r_baud + BCW'(1);
          end
        end
`endif
        // Good stop returns at mid-stop so a back-to-back start edge is not missed
        S_STOP: begin
          if (w_baud_hit) begin
            r_baud  <= '0;
            r_state <= w_rx_s ? S_IDLE : S_WAIT_HIGH;
          end else begin
            r_baud <= r_baud + BCW'(1);
          end
        end
        S_WAIT_HIGH: begin
          if (!w_rx_s) begin
            r_baud <= '0;
          end else if (w_baud_hit) begin
            r_baud  <= '0;
            r_state <= S_IDLE;
          end else begin
            r_baud <= r_baud + BCW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_baud  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_cnt   <= '0;
      r_asm   <= '0;
      r_data  <= '0;
      r_idle  <= '0;
      r_vcnt  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_byte_err | w_timeout;

      if (w_byte_err || w_timeout) begin
        r_cnt  <= '0;
        r_busy <= 1'b0;
      end else if (w_byte_ok) begin
        if (w_frame_done) begin
          r_cnt  <= '0;
          r_data <= w_asm_next;
          r_busy <= 1'b0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
          r_asm <= w_asm_next;
        end
      end else if (w_start_ok) begin
        r_busy <= 1'b1;
      end

      if ((r_state != S_IDLE) || (r_cnt == '0) || w_fall || w_timeout)
        r_idle <= '0;
      else
        r_idle <= r_idle + TW'(1);

      if (w_frame_done) begin
        r_valid <= 1'b1;
        r_vcnt  <= VLD_LAST;
      end else if (r_valid) begin
        if (r_vcnt == '0) r_valid <= 1'b0;
        else              r_vcnt  <= r_vcnt - VW'(1);
      end
    end
  end

  assign DATA_O  = r_data;
  assign VALID_O = r_valid;
  assign BUSY_O  = r_busy;
  assign ERR_O   = r_err;

endmodule
